bt_uart_tx: RTL and testbench

UART transmitter for the Bluetooth serial link: the return path that carries status bytes from the game logic back to the phone. Runs at 9600 baud, 8N1, idle-high, LSB first, on the 100 MHz system clock, so the frame format and bit timing match the existing receive side. A small write FIFO decouples the game logic from the slow line, so several bytes can be queued in consecutive cycles and sent back-to-back.

---
 rtl/bt_uart_tx.sv | 120 ++++++++++++
 tb/tb_bt_uart_tx.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/bt_uart_tx.sv
// bt_uart_tx: 8N1 UART transmitter with a small write FIFO for the Bluetooth return link.
module bt_uart_tx #(
    parameter int BPS   = 10417,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [7:0]                 wr_data,
    output logic                       tx,
    output logic                       busy,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(BPS);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [2:0]      idx, idx_n;
    logic [7:0]      sh, sh_n;
    logic            tx_n;
    logic            pop, push, last;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wp, rp;

    assign full  = level == LW'(DEPTH);
    assign empty = level == '0;
    assign push  = wr_en && !full;
    assign last  = cnt == CW'(BPS - 1);

    // FIFO storage; only written on accepted pushes, so no reset needed
    always_ff @(posedge clk)
        if (push) mem[wp] <= wr_data;

    // FIFO pointers, level and overflow pulse
    always_ff @(posedge clk)
        if (rst) begin
            wp       <= '0;
            rp       <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            wp       <= push ? wp + 1'b1 : wp;
            rp       <= pop ? rp + 1'b1 : rp;
            level    <= level + LW'(push) - LW'(pop);
            overflow <= wr_en && full;
        end

    // FSM state register with registered tx and busy
    always_ff @(posedge clk)
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            sh    <= '0;
            tx    <= 1'b1;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            sh    <= sh_n;
            tx    <= tx_n;
            busy  <= state_n != IDLE;
        end

    // Next-state logic: each bit lasts exactly BPS cycles, STOP chains straight into START
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = idx;
        sh_n    = sh;
        tx_n    = tx;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!empty) begin
                    pop     = 1'b1;
                    sh_n    = mem[rp];
                    state_n = START;
                    tx_n    = 1'b0;
                end
            end
            START:
                if (last) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = DATA;
                    tx_n    = sh[0];
                end
            DATA:
                if (last) begin
                    cnt_n = '0;
                    if (idx != 3'd7) begin
                        sh_n  = {1'b0, sh[7:1]};
                        idx_n = idx + 3'd1;
                        tx_n  = sh[1];
                    end else begin
                        state_n = STOP;
                        tx_n    = 1'b1;
                    end
                end
            default:
                if (last) begin
                    cnt_n   = '0;
                    pop     = !empty;
                    sh_n    = empty ? sh : mem[rp];
                    state_n = empty ? IDLE : START;
                    tx_n    = empty;
                end
        endcase
    end
endmodule

// File: tb/tb_bt_uart_tx.sv
// tb_bt_uart_tx: directed checks of the UART transmitter FIFO, framing and reset behaviour.
module tb_bt_uart_tx;
    localparam int BPS   = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       tx, busy, full, empty, overflow;
    logic [2:0] level;

    int vectors = 0;
    int miscompares = 0;

    bt_uart_tx #(.BPS(BPS), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .tx(tx), .busy(busy), .full(full), .empty(empty),
        .level(level), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Walk frame positions [from,to): tx must follow the 8N1 pattern every cycle,
    // busy must stay high, and the mid-bit samples must decode to b.
    task automatic line_frame(input logic [7:0] b, input string tag, input int from, input int to);
        logic [9:0] f;
        logic [7:0] d;
        int bad;
        f = {1'b1, b, 1'b0};
        d = '0;
        bad = 0;
        for (int i = from; i < to; i++) begin
            if (tx !== f[i/BPS]) bad++;
            if (busy !== 1'b1) bad++;
            if (i % BPS == BPS/2 && i >= BPS && i < 9*BPS) d[i/BPS-1] = tx;
            tick();
        end
        chk({tag, "_line"}, bad, 0);
        chk({tag, "_byte"}, {24'd0, d}, {24'd0, b});
    endtask

    task automatic write(input logic [7:0] b);
        wr_en = 1'b1;
        wr_data = b;
        tick();
        wr_en = 1'b0;
    endtask

    initial begin
        int lows;
        rst = 1'b1;
        wr_en = 1'b0;
        wr_data = 8'h00;
        repeat (3) tick();
        rst = 1'b0;

        // reset state and a quiet idle line
        for (int i = 0; i < 100; i++) begin
            chk("idle", {27'd0, tx, busy, empty, overflow, full}, {27'd0, 5'b10100});
            chk("idle_level", {29'd0, level}, 32'd0);
            tick();
        end

        // single byte 0xA5
        write(8'hA5);
        chk("a5_push", {29'd0, tx, empty, busy}, {29'd0, 3'b100});
        chk("a5_level1", {29'd0, level}, 32'd1);
        tick();
        chk("a5_pop", {30'd0, tx, busy}, {30'd0, 2'b01});
        chk("a5_level0", {29'd0, level}, 32'd0);
        line_frame(8'hA5, "a5", 0, 160);
        chk("a5_end", {29'd0, tx, busy, empty}, {29'd0, 3'b101});

        // four consecutive writes from idle: the first is popped on the second edge
        wr_en = 1'b1;
        wr_data = 8'h01; tick(); chk("b2b_lvl_a", {29'd0, level}, 32'd1);
        wr_data = 8'h02; tick(); chk("b2b_lvl_b", {29'd0, level}, 32'd1);
        chk("b2b_start", {31'd0, tx}, 32'd0);
        wr_data = 8'h03; tick(); chk("b2b_lvl_c", {29'd0, level}, 32'd2);
        wr_data = 8'h04; tick(); chk("b2b_lvl_d", {29'd0, level}, 32'd3);
        wr_en = 1'b0;
        line_frame(8'h01, "b2b1", 2, 160);
        line_frame(8'h02, "b2b2", 0, 160);
        line_frame(8'h03, "b2b3", 0, 160);
        chk("b2b_empty_last_pop", {31'd0, empty}, 32'd1);
        line_frame(8'h04, "b2b4", 0, 160);
        chk("b2b_end", {30'd0, tx, busy}, {30'd0, 2'b10});

        // overflow: keep the FSM busy with 0x0F, then push 0x10..0x14
        write(8'h0F);
        tick();
        wr_en = 1'b1;
        wr_data = 8'h10; tick(); chk("ovf_lvl1", {29'd0, level}, 32'd1);
        wr_data = 8'h11; tick(); chk("ovf_lvl2", {29'd0, level}, 32'd2);
        wr_data = 8'h12; tick(); chk("ovf_lvl3", {29'd0, level}, 32'd3);
        wr_data = 8'h13; tick(); chk("ovf_lvl4", {29'd0, level}, 32'd4);
        chk("ovf_full", {30'd0, full, overflow}, {30'd0, 2'b10});
        wr_data = 8'h14; tick();
        chk("ovf_pulse", {30'd0, full, overflow}, {30'd0, 2'b11});
        chk("ovf_lvl_kept", {29'd0, level}, 32'd4);
        wr_en = 1'b0;
        tick();
        chk("ovf_clear", {31'd0, overflow}, 32'd0);
        line_frame(8'h0F, "ovf0f", 6, 160);
        chk("ovf_pop_lvl", {29'd0, level}, 32'd3);
        line_frame(8'h10, "ovf10", 0, 160);
        line_frame(8'h11, "ovf11", 0, 160);
        line_frame(8'h12, "ovf12", 0, 160);
        line_frame(8'h13, "ovf13", 0, 160);
        chk("ovf_end", {29'd0, tx, busy, empty}, {29'd0, 3'b101});
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            if (tx !== 1'b1) lows++;
            tick();
        end
        chk("ovf_no_0x14", lows, 0);

        // push on the STOP->START pop edge with two bytes queued
        write(8'h20);
        wr_en = 1'b1;
        wr_data = 8'h21; tick();
        wr_data = 8'h22; tick();
        wr_en = 1'b0;
        chk("pp_lvl2", {29'd0, level}, 32'd2);
        line_frame(8'h20, "pp20", 1, 159);
        write(8'h23);
        chk("pp_lvl_same", {29'd0, level}, 32'd2);
        chk("pp_start", {31'd0, tx}, 32'd0);
        line_frame(8'h21, "pp21", 0, 160);
        line_frame(8'h22, "pp22", 0, 160);
        line_frame(8'h23, "pp23", 0, 160);
        chk("pp_end", {30'd0, busy, empty}, {30'd0, 2'b01});

        // reset mid-DATA of 0xFF with two bytes queued
        write(8'hFF);
        wr_en = 1'b1;
        wr_data = 8'h31; tick();
        wr_data = 8'h32; tick();
        wr_en = 1'b0;
        repeat (40) tick();
        chk("rst_pre", {30'd0, busy, empty}, {30'd0, 2'b10});
        chk("rst_pre_lvl", {29'd0, level}, 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_state", {28'd0, tx, busy, empty, overflow}, {28'd0, 4'b1010});
        chk("rst_lvl", {29'd0, level}, 32'd0);
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
            tick();
        end
        chk("rst_quiet", lows, 0);
        write(8'h5A);
        tick();
        line_frame(8'h5A, "rst5a", 0, 160);
        chk("rst5a_end", {29'd0, tx, busy, empty}, {29'd0, 3'b101});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
